// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Brief    : EX/MEM pipeline register with valid/ready handshake, overflow
//             write squash, sticky overflow exception record and saturating
//             overflow counter.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_overflow,
  input  logic              in_zero,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic [PC_W-1:0]   out_pc,
  output logic              exc_valid,
  output logic [PC_W-1:0]   exc_pc,
  input  logic              exc_ack,
  output logic [CNT_W-1:0]  ovf_count
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_zero_q, out_zero_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              out_regwrite_q, out_regwrite_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic              exc_valid_q, exc_valid_d;
  logic [PC_W-1:0]   exc_pc_q, exc_pc_d;
  logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

  logic w_acc;
  logic w_drain;
  logic w_set;

  // Ready depends only on held state and out_ready; forced high while in reset.
  assign in_ready = !rst_n || !out_valid_q || out_ready;
  assign w_acc    = in_valid && in_ready && !flush;
  assign w_drain  = out_valid_q && out_ready;
  assign w_set    = w_acc && in_overflow;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_rd_d       = out_rd_q;
    out_regwrite_d = out_regwrite_q;
    out_pc_d       = out_pc_q;
    exc_valid_d    = exc_valid_q;
    exc_pc_d       = exc_pc_q;
    ovf_count_d    = ovf_count_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_acc) begin
      out_valid_d = 1'b1;
    end else if (w_drain) begin
      out_valid_d = 1'b0;
    end

    if (w_acc) begin
      out_result_d   = in_result;
      out_zero_d     = in_zero;
      out_rd_d       = in_rd;
      out_regwrite_d = in_regwrite && !in_overflow && (in_rd != '0);
      out_pc_d       = in_pc;
    end

    if (w_set && !(&ovf_count_q)) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end

    // A new overflow coinciding with an ack replaces the recorded PC.
    if (w_set) begin
      exc_valid_d = 1'b1;
      if (!exc_valid_q || exc_ack) begin
        exc_pc_d = in_pc;
      end
    end else if (exc_ack) begin
      exc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_rd_q       <= '0;
      out_regwrite_q <= 1'b0;
      out_pc_q       <= '0;
      exc_valid_q    <= 1'b0;
      exc_pc_q       <= '0;
      ovf_count_q    <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_rd_q       <= out_rd_d;
      out_regwrite_q <= out_regwrite_d;
      out_pc_q       <= out_pc_d;
      exc_valid_q    <= exc_valid_d;
      exc_pc_q       <= exc_pc_d;
      ovf_count_q    <= ovf_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_zero     = out_zero_q;
  assign out_rd       = out_rd_q;
  assign out_regwrite = out_regwrite_q;
  assign out_pc       = out_pc_q;
  assign exc_valid    = exc_valid_q;
  assign exc_pc       = exc_pc_q;
  assign ovf_count    = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Brief    : Directed, table-driven self-checking bench for ex_mem_stage
//             (built with CNT_W=2 so counter saturation is reachable).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_overflow, in_zero, in_regwrite;
  logic [31:0] in_result, in_pc, out_result, out_pc, exc_pc;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_zero, out_regwrite, exc_valid, exc_ack;
  logic [1:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .PC_W(32), .RD_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_overflow(in_overflow), .in_zero(in_zero),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_pc(out_pc),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_ack(exc_ack),
    .ovf_count(ovf_count)
  );

  typedef struct packed {
    logic        rst_n, flush, in_valid;
    logic [31:0] res;
    logic        ovf, zero;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] pc;
    logic        out_ready, ack;
    logic        e_ready, e_ov;
    logic [31:0] e_res;
    logic        e_z;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [31:0] e_pc;
    logic        e_exc;
    logic [31:0] e_epc;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] res,
                       input logic ovf, input logic z, input logic [4:0] rd, input logic rw,
                       input logic [31:0] pc, input logic ordy, input logic ack);
    rst_n = r; flush = f; in_valid = v; in_result = res; in_overflow = ovf; in_zero = z;
    in_rd = rd; in_regwrite = rw; in_pc = pc; out_ready = ordy; exc_ack = ack;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.rst_n, v.flush, v.in_valid, v.res, v.ovf, v.zero, v.rd, v.rw, v.pc, v.out_ready, v.ack);
    #1;
    chk({t, ".in_ready"}, 32'(in_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    chk({t, ".out_valid"},    32'(out_valid),    32'(v.e_ov));
    chk({t, ".out_result"},   out_result,        v.e_res);
    chk({t, ".out_zero"},     32'(out_zero),     32'(v.e_z));
    chk({t, ".out_rd"},       32'(out_rd),       32'(v.e_rd));
    chk({t, ".out_regwrite"}, 32'(out_regwrite), 32'(v.e_rw));
    chk({t, ".out_pc"},       out_pc,            v.e_pc);
    chk({t, ".exc_valid"},    32'(exc_valid),    32'(v.e_exc));
    chk({t, ".exc_pc"},       exc_pc,            v.e_epc);
    chk({t, ".ovf_count"},    32'(ovf_count),    32'(v.e_cnt));
  endtask

  function automatic vec_t mk(
      input logic r, input logic f, input logic v, input logic [31:0] res, input logic ovf,
      input logic z, input logic [4:0] rd, input logic rw, input logic [31:0] pc,
      input logic ordy, input logic ack,
      input logic erdy, input logic eov, input logic [31:0] eres, input logic ez,
      input logic [4:0] erd, input logic erw, input logic [31:0] epc, input logic eexc,
      input logic [31:0] eepc, input logic [1:0] ecnt);
    return '{r, f, v, res, ovf, z, rd, rw, pc, ordy, ack,
             erdy, eov, eres, ez, erd, erw, epc, eexc, eepc, ecnt};
  endfunction

  initial begin
    //            rst  fl   vld  result        ovf  z    rd     rw   pc            ordy ack  | rdy  ov   result        z    rd     rw   pc            exc  exc_pc        cnt
    vecs[0]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,5'd0, 1'b0,32'h0,       1'b0,1'b0, 1'b1,1'b0,32'h0,        1'b0,5'd0, 1'b0,32'h0,       1'b0,32'h0,  2'd0);
    vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,5'd0, 1'b0,32'h0,       1'b0,1'b0, 1'b1,1'b0,32'h0,        1'b0,5'd0, 1'b0,32'h0,       1'b0,32'h0,  2'd0);
    vecs[2]  = mk(1'b1,1'b0,1'b1,32'h5,        1'b0,1'b0,5'd3, 1'b1,32'h100,     1'b1,1'b0, 1'b1,1'b1,32'h5,        1'b0,5'd3, 1'b1,32'h100,     1'b0,32'h0,  2'd0);
    vecs[3]  = mk(1'b1,1'b0,1'b1,32'h8000_0000,1'b1,1'b0,5'd4, 1'b1,32'h200,     1'b1,1'b0, 1'b1,1'b1,32'h8000_0000,1'b0,5'd4, 1'b0,32'h200,     1'b1,32'h200,2'd1);
    vecs[4]  = mk(1'b1,1'b0,1'b1,32'h7FFF_FFFF,1'b1,1'b0,5'd5, 1'b1,32'h204,     1'b1,1'b0, 1'b1,1'b1,32'h7FFF_FFFF,1'b0,5'd5, 1'b0,32'h204,     1'b1,32'h200,2'd2);
    // flush drops an overflowing input: counter and exception untouched
    vecs[5]  = mk(1'b1,1'b1,1'b1,32'hDEAD,     1'b1,1'b1,5'd9, 1'b1,32'h500,     1'b1,1'b0, 1'b1,1'b0,32'h7FFF_FFFF,1'b0,5'd5, 1'b0,32'h204,     1'b1,32'h200,2'd2);
    vecs[6]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,5'd0, 1'b0,32'h0,       1'b1,1'b1, 1'b1,1'b0,32'h7FFF_FFFF,1'b0,5'd5, 1'b0,32'h204,     1'b0,32'h200,2'd2);
    vecs[7]  = mk(1'b1,1'b0,1'b1,32'h0,        1'b1,1'b1,5'd6, 1'b1,32'h200,     1'b1,1'b0, 1'b1,1'b1,32'h0,        1'b1,5'd6, 1'b0,32'h200,     1'b1,32'h200,2'd3);
    // ack coincident with a new overflow: record replaced, counter saturated
    vecs[8]  = mk(1'b1,1'b0,1'b1,32'h1,        1'b1,1'b0,5'd7, 1'b1,32'h300,     1'b1,1'b1, 1'b1,1'b1,32'h1,        1'b0,5'd7, 1'b0,32'h300,     1'b1,32'h300,2'd3);
    vecs[9]  = mk(1'b1,1'b0,1'b1,32'h1234,     1'b0,1'b0,5'd0, 1'b1,32'h400,     1'b1,1'b0, 1'b1,1'b1,32'h1234,     1'b0,5'd0, 1'b0,32'h400,     1'b1,32'h300,2'd3);
    vecs[10] = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,5'd0, 1'b0,32'h0,       1'b0,1'b0, 1'b0,1'b1,32'h1234,     1'b0,5'd0, 1'b0,32'h400,     1'b1,32'h300,2'd3);
    vecs[11] = mk(1'b0,1'b0,1'b1,32'hFFFF,     1'b1,1'b1,5'd1, 1'b1,32'h900,     1'b0,1'b0, 1'b1,1'b0,32'h0,        1'b0,5'd0, 1'b0,32'h0,       1'b0,32'h0,  2'd0);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    // Back-pressure: hold 0xA while 0xB waits for three cycles.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'hA, 1'b0, 1'b0, 5'd2, 1'b1, 32'h600, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("bp.load_a", out_result, 32'hA);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 5'd2, 1'b1, 32'h604, 1'b0, 1'b0);
      #1;
      chk("bp.in_ready_low", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("bp.hold_a", out_result, 32'hA);
      chk("bp.hold_valid", 32'(out_valid), 32'h1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_release", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("bp.b_appears", out_result, 32'hB);
    chk("bp.b_pc", out_pc, 32'h604);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp.no_duplicate", 32'(out_valid), 32'h0);

    // Saturation from a clean reset: 1,2,3,3,3.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("sat.reset", 32'(ovf_count), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 5'd1, 1'b1, 32'h700 + 32'(k * 4), 1'b1, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("sat.count%0d", k), 32'(ovf_count), (k < 3) ? 32'(k + 1) : 32'h3);
      chk($sformatf("sat.exc_pc%0d", k), exc_pc, 32'h700);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
